// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port 256x8 memory between loader (LD), data (DM) and fetch (IF).
// Fixed LD > DM > IF priority, loader bus lock, and a fetch starvation guard.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 32'd3,
    parameter int unsigned STALL_W      = 32'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_req,
    input  logic               ld_we,
    input  logic [7:0]         ld_addr,
    input  logic [7:0]         ld_wdata,
    input  logic               ld_lock,
    output logic               ld_gnt,
    output logic               ld_rvalid,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [7:0]         dm_addr,
    input  logic [7:0]         dm_wdata,
    output logic               dm_gnt,
    output logic               dm_rvalid,
    input  logic               if_req,
    input  logic [7:0]         if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [7:0]         rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [7:0]         mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata,
    output logic [STALL_W-1:0] if_stall_cycles
);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0]         STARVE_LIM_C = STARVE_LIMIT[3:0];
    localparam logic               GUARD_EN_C   = (STARVE_LIMIT != 32'd0);
    localparam logic [STALL_W-1:0] STALL_MAX_C  = {STALL_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_ONE_C  = {{(STALL_W-1){1'b0}}, 1'b1};

    state_t               state_r, state_nxt_s;
    logic [3:0]           starve_cnt_r, starve_cnt_nxt_s;
    logic [STALL_W-1:0]   stall_r;
    logic [7:0]           addr_hold_r, wdata_hold_r;
    logic                 ld_rvalid_r, dm_rvalid_r, if_rvalid_r;
    logic                 ld_gnt_s, dm_gnt_s, if_gnt_s;
    logic                 locked_eff_s;
    logic                 mem_we_s;
    logic [7:0]           mem_addr_s, mem_wdata_s;

    // Grant selection; a dropped lock already arbitrates as ARB in the same cycle.
    always_comb begin
        ld_gnt_s     = 1'b0;
        dm_gnt_s     = 1'b0;
        if_gnt_s     = 1'b0;
        locked_eff_s = (state_r == LOCKED) && ld_lock;
        if (rst) begin
            ld_gnt_s = 1'b0;
        end else if (locked_eff_s) begin
            ld_gnt_s = ld_req;
        end else if (ld_req) begin
            ld_gnt_s = 1'b1;
        end else if (dm_req && if_req && GUARD_EN_C && (starve_cnt_r == STARVE_LIM_C)) begin
            if_gnt_s = 1'b1;
        end else if (dm_req) begin
            dm_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
        end
    end

    // Lock FSM next state and starvation counter update.
    always_comb begin
        state_nxt_s      = state_r;
        starve_cnt_nxt_s = starve_cnt_r;
        case (state_r)
            ARB:     state_nxt_s = (ld_gnt_s && ld_lock) ? LOCKED : ARB;
            LOCKED:  state_nxt_s = ld_lock ? LOCKED : ARB;
            default: state_nxt_s = ARB;
        endcase
        if (locked_eff_s || ld_gnt_s) begin
            starve_cnt_nxt_s = starve_cnt_r;
        end else if (!if_req || if_gnt_s) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (dm_gnt_s && (starve_cnt_r != 4'hF)) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Memory-side mux; address and data hold their last value when idle.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = addr_hold_r;
        mem_wdata_s = wdata_hold_r;
        if (ld_gnt_s) begin
            mem_we_s    = ld_we;
            mem_addr_s  = ld_addr;
            mem_wdata_s = ld_wdata;
        end else if (dm_gnt_s) begin
            mem_we_s    = dm_we;
            mem_addr_s  = dm_addr;
            mem_wdata_s = dm_wdata;
        end else if (if_gnt_s) begin
            mem_addr_s  = if_addr;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // State, counters, held bus values and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ARB;
            starve_cnt_r <= 4'd0;
            stall_r      <= {STALL_W{1'b0}};
            addr_hold_r  <= 8'd0;
            wdata_hold_r <= 8'd0;
            ld_rvalid_r  <= 1'b0;
            dm_rvalid_r  <= 1'b0;
            if_rvalid_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            if (if_req && !if_gnt_s && (stall_r != STALL_MAX_C)) begin
                stall_r <= stall_r + STALL_ONE_C;
            end else begin
                stall_r <= stall_r;
            end
            addr_hold_r  <= mem_addr_s;
            wdata_hold_r <= mem_wdata_s;
            ld_rvalid_r  <= ld_gnt_s && !ld_we;
            dm_rvalid_r  <= dm_gnt_s && !dm_we;
            if_rvalid_r  <= if_gnt_s;
        end
    end

    // A read pending when reset arrives never reports its data.
    assign ld_rvalid       = ld_rvalid_r && !rst;
    assign dm_rvalid       = dm_rvalid_r && !rst;
    assign if_rvalid       = if_rvalid_r && !rst;
    assign ld_gnt          = ld_gnt_s;
    assign dm_gnt          = dm_gnt_s;
    assign if_gnt          = if_gnt_s;
    assign mem_en          = ld_gnt_s | dm_gnt_s | if_gnt_s;
    assign mem_we          = mem_we_s;
    assign mem_addr        = mem_addr_s;
    assign mem_wdata       = mem_wdata_s;
    assign rdata           = mem_rdata;
    assign if_stall_cycles = stall_r;

endmodule
